header_dispatcher: RTL and testbench
====================================

Name: header_dispatcher

Overview:
- Node-0 injection stage that feeds the mining processing elements (PEs) over the NoC.
- Latches one 640-bit block header and streams it as 10-flit wormhole packets, one packet per PE, round-robin over destinations FIRST_DEST..FIRST_DEST+num_pe-1.
- Respects credit-based flow control on the router injection port.
- Repeats the sweep until stopped, because each PE consumes one header per nonce attempt.

Parameters:
- FLIT_DATA_WIDTH, 64, payload bits per flit.
- DEST_BITS, 5, destination field width.
- VC_BITS, 2, virtual-channel field width.
- HDR_FLITS, 10, flits per header packet.
- BUF_DEPTH, 8, injection-port credits per VC at reset.
- FIRST_DEST, 1, router id of the first PE.

Ports:
- sys_clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse: latch header_in, num_pe, loop; begin sending.
- header_in  in  640  block header; flit k carries header_in[64k+63:64k].
- num_pe  in  5  number of PEs addressed (1..24 legal; 0 treated as 1).
- loop  in  1  1 = repeat sweeps until stop; 0 = one sweep then idle.
- stop  in  1  level; finish the current packet, then go idle.
- EN_getCredit  in  1  credit return strobe from the router.
- getCredit  in  1+VC_BITS  {valid, vc}; only vc 0 is counted.
- EN_putFlit  out  1  flit valid to the router.
- putFlit  out  2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS  {valid, tail, dest, vc, data}.
- busy  out  1  high outside IDLE.
- headers_sent  out  32  completed packets since the last start.
- credit_err  out  1  sticky: credit returned while the counter was already at BUF_DEPTH.

Behaviour:
- Reset values (reset==0 at a clock edge): state IDLE; EN_putFlit=0; putFlit=0; busy=0; headers_sent=0; credit_err=0; credits=BUF_DEPTH; flit_idx=0; dest=FIRST_DEST.
- All outputs are registered.
- IDLE:
  - start=1 latches the header, num_pe (0→1) and loop; clears headers_sent; moves to SEND. busy rises the next cycle.
  - start outside IDLE is ignored.
- SEND, each cycle:
  - If credits>0, drive EN_putFlit=1 and putFlit={1, tail=(flit_idx==9), dest, 2'd0, hdr[64*flit_idx+:64]}; decrement credits; flit_idx++.
  - Otherwise EN_putFlit=0 and putFlit=0; flit_idx, dest and header are held.
- Packet end (tail flit sent):
  - flit_idx←0; headers_sent++.
  - dest←dest+1, wrapping from FIRST_DEST+num_pe-1 back to FIRST_DEST.
  - If the wrap occurs with loop=0 → DRAIN.
- stop:
  - Sampled every SEND cycle. If flit_idx==0 (packet boundary) → DRAIN and no flit is sent that cycle.
  - Otherwise remember stop_pend and go to DRAIN after the tail flit.
  - A packet is never truncated.
- DRAIN: EN_putFlit=0 for one cycle → IDLE.
- Latency: first flit appears 2 cycles after the start pulse, given credits. Throughput is 1 flit/cycle while credits last.
- Credits:
  - Increment on EN_getCredit & getCredit[valid] & vc==0.
  - A simultaneous send and return leaves the count unchanged.
  - An increment at BUF_DEPTH saturates and sets credit_err.
  - Returns on vc≠0 are ignored.
- headers_sent wraps modulo 2^32.
- Reset mid-packet: everything returns to reset values; the partially sent packet is abandoned. The system resets the NoC together with this block.

Decomposition:
- Shared package/include: flit field widths, the putFlit bit-slice positions (valid, tail, dest, vc, data), the credit format, FOUND_BITCOIN_MSG and the PE count constant. PEs and the future result collector share these.
- One sub-module, credit_counter (per-VC counter with saturation and error flag), is natural. The FSM and flit mux stay in header_dispatcher.

Test Plan:
- Reset with reset=0 for 2 cycles → EN_putFlit=0, putFlit=0, busy=0, credit counter=8, headers_sent=0.
- start with num_pe=2, loop=0, header_in=known pattern, credits echoed back 1 cycle after each flit → 20 flits:
  - dest 1 for flits 0..9, then dest 2 for flits 10..19;
  - tail bit only on flits 9 and 19;
  - data of flit k = header_in[64k+63:64k];
  - headers_sent=2; busy drops afterwards.
- No credit returns, num_pe=1 → exactly 8 flits sent, then EN_putFlit=0 with flit_idx held at 8. Return 2 credits → flits 8 and 9 (tail) are sent.
- loop=1, num_pe=3 → destinations follow 1,2,3,1,…; assert stop during flit 4 of the 5th packet → packet finishes with its tail, then idle; headers_sent=5.
- 9 credit returns with none consumed → credit counter stays 8 and credit_err=1. A simultaneous send and return → count unchanged.
- reset asserted on flit 6, then start again → first flit is flit 0 to dest 1; headers_sent=0.

Source files
------------

// File: rtl/header_dispatcher_pkg.sv
// rtl/header_dispatcher_pkg.sv - flit, credit and PE constants shared by the mining NoC blocks
package header_dispatcher_pkg;

  localparam int FLIT_DATA_WIDTH = 64;
  localparam int DEST_BITS       = 5;
  localparam int VC_BITS         = 2;
  localparam int HDR_FLITS       = 10;
  localparam int BUF_DEPTH       = 8;
  localparam int FIRST_DEST      = 1;
  localparam int NUM_PE_MAX      = 24;

  localparam int FLIT_WIDTH   = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;
  localparam int CREDIT_WIDTH = 1 + VC_BITS;

  // putFlit = {valid, tail, dest, vc, data}; getCredit = {valid, vc}
  localparam int FLIT_DATA_LSB    = 0;
  localparam int FLIT_VC_LSB      = FLIT_DATA_WIDTH;
  localparam int FLIT_DEST_LSB    = FLIT_VC_LSB + VC_BITS;
  localparam int FLIT_TAIL_BIT    = FLIT_DEST_LSB + DEST_BITS;
  localparam int FLIT_VALID_BIT   = FLIT_TAIL_BIT + 1;
  localparam int CREDIT_VALID_BIT = VC_BITS;

  localparam logic [FLIT_DATA_WIDTH-1:0] FOUND_BITCOIN_MSG = 64'hB17C_0140_F0C0_D00D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DRAIN
  } dispatch_state_t;

endpackage

// File: rtl/header_dispatcher_credit_counter.sv
// rtl/header_dispatcher_credit_counter.sv - injection-port credit counter with saturation and sticky error
module credit_counter
  import header_dispatcher_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int CNT_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             consume,
  input  logic             give_back,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      count <= CNT_W'(DEPTH);
      err   <= 1'b0;
    end else begin
      case ({consume, give_back})
        2'b10: count <= count - CNT_W'(1);
        2'b01: begin
          // a return with the buffer already full means the router over-credited us
          if (count == CNT_W'(DEPTH)) err <= 1'b1;
          else count <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/header_dispatcher.sv
// rtl/header_dispatcher.sv - latches a block header and streams it round-robin to the PEs as wormhole packets
module header_dispatcher #(
  parameter int FLIT_DATA_WIDTH = header_dispatcher_pkg::FLIT_DATA_WIDTH,
  parameter int DEST_BITS       = header_dispatcher_pkg::DEST_BITS,
  parameter int VC_BITS         = header_dispatcher_pkg::VC_BITS,
  parameter int HDR_FLITS       = header_dispatcher_pkg::HDR_FLITS,
  parameter int BUF_DEPTH       = header_dispatcher_pkg::BUF_DEPTH,
  parameter int FIRST_DEST      = header_dispatcher_pkg::FIRST_DEST
) (
  input  logic                                       sys_clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [HDR_FLITS*FLIT_DATA_WIDTH-1:0]       header_in,
  input  logic [DEST_BITS-1:0]                       num_pe,
  input  logic                                       loop,
  input  logic                                       stop,
  input  logic                                       EN_getCredit,
  input  logic [VC_BITS:0]                           getCredit,
  output logic                                       EN_putFlit,
  output logic [2+DEST_BITS+VC_BITS+FLIT_DATA_WIDTH-1:0] putFlit,
  output logic                                       busy,
  output logic [31:0]                                headers_sent,
  output logic                                       credit_err
);
  import header_dispatcher_pkg::*;

  localparam int IDX_W = $clog2(HDR_FLITS);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  dispatch_state_t state, state_next;

  logic [FLIT_DATA_WIDTH-1:0] hdr_flits [HDR_FLITS];
  logic [IDX_W-1:0]           flit_idx;
  logic [DEST_BITS-1:0]       dest;
  logic [DEST_BITS-1:0]       num_pe_l;
  logic                       loop_l;
  logic                       stop_pend;
  logic [CNT_W-1:0]           credits;
  logic [DEST_BITS:0]         last_dest;
  logic                       credit_ret;
  logic                       tail;
  logic                       at_wrap;
  logic                       send;

  assign credit_ret = EN_getCredit && getCredit[VC_BITS] && (getCredit[VC_BITS-1:0] == '0);
  assign tail       = (flit_idx == IDX_W'(HDR_FLITS - 1));
  assign last_dest  = (DEST_BITS+1)'(FIRST_DEST) + {1'b0, num_pe_l} - (DEST_BITS+1)'(1);
  assign at_wrap    = ({1'b0, dest} == last_dest);

  credit_counter #(
    .DEPTH(BUF_DEPTH),
    .CNT_W(CNT_W)
  ) u_credit_counter (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .consume  (send),
    .give_back(credit_ret),
    .count    (credits),
    .err      (credit_err)
  );

  always_ff @(posedge sys_clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    send       = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_SEND;
      ST_SEND: begin
        // stop only takes effect between packets; mid-packet it is deferred to the tail
        if (stop && flit_idx == '0) begin
          state_next = ST_DRAIN;
        end else if (credits != '0) begin
          send = 1'b1;
          if (tail && (stop || stop_pend || (at_wrap && !loop_l))) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (state == ST_IDLE && start) begin
      for (int k = 0; k < HDR_FLITS; k++) begin
        hdr_flits[k] <= header_in[k*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      flit_idx     <= '0;
      dest         <= DEST_BITS'(FIRST_DEST);
      num_pe_l     <= DEST_BITS'(1);
      loop_l       <= 1'b0;
      stop_pend    <= 1'b0;
      headers_sent <= '0;
      EN_putFlit   <= 1'b0;
      putFlit      <= '0;
      busy         <= 1'b0;
    end else begin
      EN_putFlit <= send;
      putFlit    <= send ? {1'b1, tail, dest, VC_BITS'(0), hdr_flits[flit_idx]} : '0;
      busy       <= (state_next != ST_IDLE);

      if (state == ST_IDLE && start) begin
        num_pe_l     <= (num_pe == '0) ? DEST_BITS'(1) : num_pe;
        loop_l       <= loop;
        flit_idx     <= '0;
        dest         <= DEST_BITS'(FIRST_DEST);
        stop_pend    <= 1'b0;
        headers_sent <= '0;
      end

      if (state == ST_SEND && stop && flit_idx != '0) stop_pend <= 1'b1;

      if (send) begin
        if (tail) begin
          flit_idx     <= '0;
          headers_sent <= headers_sent + 32'd1;
          dest         <= at_wrap ? DEST_BITS'(FIRST_DEST) : dest + DEST_BITS'(1);
        end else begin
          flit_idx <= flit_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_header_dispatcher.sv
// tb/tb_header_dispatcher.sv - randomized self-checking bench for header_dispatcher
module tb_header_dispatcher;
  import header_dispatcher_pkg::*;

  logic                  sys_clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic [639:0]          header_in = '0;
  logic [4:0]            num_pe = '0;
  logic                  loop = 1'b0;
  logic                  stop = 1'b0;
  logic                  EN_getCredit = 1'b0;
  logic [2:0]            getCredit = '0;
  logic                  EN_putFlit;
  logic [72:0]           putFlit;
  logic                  busy;
  logic [31:0]           headers_sent;
  logic                  credit_err;

  int                    n_checks = 0;
  int                    n_fail = 0;
  int                    owed = 0;
  int                    echo_mode = 0;
  logic [72:0]           obs_q[$];
  logic [72:0]           exp_q[$];
  logic [63:0]           hdr_words[10];

  header_dispatcher dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .start       (start),
    .header_in   (header_in),
    .num_pe      (num_pe),
    .loop        (loop),
    .stop        (stop),
    .EN_getCredit(EN_getCredit),
    .getCredit   (getCredit),
    .EN_putFlit  (EN_putFlit),
    .putFlit     (putFlit),
    .busy        (busy),
    .headers_sent(headers_sent),
    .credit_err  (credit_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock: collect any flit, then drive the router's credit returns for the next edge
  task automatic tick();
    logic ret;
    @(posedge sys_clk);
    #1;
    ret = 1'b0;
    if (EN_putFlit === 1'b1) begin
      obs_q.push_back(putFlit);
      owed++;
    end
    if (echo_mode == 1 && EN_putFlit === 1'b1) ret = 1'b1;
    if (echo_mode == 2 && owed > 0 && $urandom_range(0, 1) == 1) ret = 1'b1;
    EN_getCredit = ret;
    getCredit    = ret ? 3'b100 : 3'b000;
    if (ret) owed--;
  endtask

  task automatic give_credit();
    EN_getCredit = 1'b1;
    getCredit    = 3'b100;
    owed--;
    tick();
  endtask

  task automatic drain_credits();
    while (owed > 0) give_credit();
  endtask

  function automatic logic [639:0] rand_hdr();
    logic [639:0] h;
    for (int i = 0; i < 20; i++) h[i*32 +: 32] = $urandom;
    return h;
  endfunction

  task automatic do_start(input logic [639:0] h, input logic [4:0] np, input logic lp);
    for (int k = 0; k < 10; k++) hdr_words[k] = h[k*64 +: 64];
    header_in = h;
    num_pe    = np;
    loop      = lp;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    header_in = rand_hdr();
    num_pe    = 5'($urandom);
  endtask

  // expected stream: packet p goes to PE (p mod num_pe), flits carry the header words in order
  function automatic void build_exp(input int np, input int npk);
    int npe;
    npe = (np == 0) ? 1 : np;
    exp_q.delete();
    for (int p = 0; p < npk; p++) begin
      for (int k = 0; k < 10; k++) begin
        exp_q.push_back({1'b1, (k == 9) ? 1'b1 : 1'b0, 5'(FIRST_DEST + (p % npe)), 2'b00, hdr_words[k]});
      end
    end
  endfunction

  task automatic compare_flits(input string tag);
    check({tag, "_nflits"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_flit%0d", tag, i), obs_q[i], exp_q[i]);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < budget) begin
      tick();
      i++;
    end
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_flits(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (obs_q.size() < n && i < budget) begin
      tick();
      i++;
    end
    check({tag, "_reach"}, obs_q.size() >= n, 1'b1);
  endtask

  initial begin
    logic [639:0] h;
    int np, npk, n_stop;
    logic lp;

    // reset state
    repeat (2) tick();
    check("rst_en", EN_putFlit, 1'b0);
    check("rst_flit", putFlit, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_sent", headers_sent, 32'd0);
    check("rst_err", credit_err, 1'b0);
    reset = 1'b1;
    tick();

    // two PEs, one sweep, credits echoed one cycle after each flit
    echo_mode = 1;
    obs_q.delete();
    h = rand_hdr();
    do_start(h, 5'd2, 1'b0);
    check("t2_busy_rise", busy, 1'b1);
    check("t2_no_flit_yet", EN_putFlit, 1'b0);
    tick();
    check("t2_first_flit", EN_putFlit, 1'b1);
    wait_idle("t2", 200);
    build_exp(2, 2);
    compare_flits("t2");
    check("t2_sent", headers_sent, 32'd2);

    // no returns: exactly BUF_DEPTH flits, then stall mid-packet
    echo_mode = 0;
    obs_q.delete();
    h = rand_hdr();
    do_start(h, 5'd1, 1'b0);
    repeat (20) tick();
    check("t3_stall_n", obs_q.size(), 8);
    check("t3_stall_en", EN_putFlit, 1'b0);
    check("t3_stall_busy", busy, 1'b1);
    give_credit();
    give_credit();
    wait_idle("t3", 50);
    build_exp(1, 1);
    compare_flits("t3");
    check("t3_sent", headers_sent, 32'd1);
    drain_credits();

    // looping sweep over three PEs, stop mid-way through the fifth packet
    echo_mode = 2;
    obs_q.delete();
    h = rand_hdr();
    do_start(h, 5'd3, 1'b1);
    wait_flits("t4", 44, 1000);
    n_stop = obs_q.size();
    stop = 1'b1;
    wait_idle("t4", 400);
    stop = 1'b0;
    build_exp(3, (n_stop + 9) / 10);
    compare_flits("t4");
    check("t4_sent", headers_sent, 32'd5);
    drain_credits();

    // random sweeps with random credit timing and a start pulse while busy
    for (int t = 0; t < 6; t++) begin
      obs_q.delete();
      h  = rand_hdr();
      np = $urandom_range(0, 24);
      lp = 1'($urandom_range(0, 1));
      do_start(h, 5'(np), lp);
      wait_flits($sformatf("r%0d_a", t), 3, 200);
      header_in = rand_hdr();
      num_pe    = 5'($urandom);
      start     = 1'b1;
      tick();
      start     = 1'b0;
      if (lp) begin
        n_stop = $urandom_range(4, 60);
        wait_flits($sformatf("r%0d_b", t), n_stop, 1000);
        n_stop = obs_q.size();
        stop = 1'b1;
        npk = (n_stop + 9) / 10;
      end else begin
        npk = (np == 0) ? 1 : np;
      end
      wait_idle($sformatf("r%0d", t), 5000);
      stop = 1'b0;
      build_exp(np, npk);
      compare_flits($sformatf("r%0d", t));
      check($sformatf("r%0d_sent", t), headers_sent, 32'(npk));
      drain_credits();
    end

    // over-return saturates and flags; vc!=0 and invalid returns are ignored
    echo_mode = 0;
    check("ce_clean", credit_err, 1'b0);
    for (int i = 0; i < 9; i++) begin
      EN_getCredit = 1'b1;
      getCredit    = 3'b100;
      tick();
    end
    check("ce_set", credit_err, 1'b1);
    obs_q.delete();
    h = rand_hdr();
    do_start(h, 5'd1, 1'b0);
    repeat (20) tick();
    check("ce_still_8", obs_q.size(), 8);
    for (int i = 0; i < 4; i++) begin
      EN_getCredit = 1'b1;
      getCredit    = (i == 3) ? 3'b000 : 3'(4 + i + 1);
      tick();
    end
    EN_getCredit = 1'b0;
    getCredit    = 3'b100;
    tick();
    repeat (4) tick();
    check("ce_vc_ignored", obs_q.size(), 8);
    give_credit();
    give_credit();
    repeat (10) tick();
    check("ce_simul_n", obs_q.size(), 10);
    check("ce_simul_idle", busy, 1'b0);
    build_exp(1, 1);
    compare_flits("ce");
    drain_credits();

    // reset in the middle of a packet, then a clean restart
    echo_mode = 1;
    obs_q.delete();
    h = rand_hdr();
    do_start(h, 5'd2, 1'b1);
    wait_flits("mr", 6, 100);
    reset = 1'b0;
    tick();
    tick();
    check("mr_en", EN_putFlit, 1'b0);
    check("mr_flit", putFlit, '0);
    check("mr_busy", busy, 1'b0);
    check("mr_sent", headers_sent, 32'd0);
    check("mr_err", credit_err, 1'b0);
    reset = 1'b1;
    tick();
    obs_q.delete();
    owed = 0;
    h = rand_hdr();
    do_start(h, 5'd1, 1'b0);
    check("mr_sent_restart", headers_sent, 32'd0);
    wait_idle("mr", 100);
    build_exp(1, 1);
    compare_flits("mr");
    check("mr_sent_end", headers_sent, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
